// File: rtl/tick_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tick_receiver
//  Purpose  : Samples the divided game clock as data and turns its edges into
//             single-cycle tick enables. It also counts the emitted ticks,
//             measures the slow-clock period and flags a stall when edges stop.
//  Options  : TICK_BOTH_EDGES_EN - tick on both slow-clock transitions
//  Revision : 1.0 - initial release
// ============================================================================
module tick_receiver #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 32'd110000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk_in,
    input  logic             enable,
    output logic             tick,
    output logic [15:0]      tick_count,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_ONE          = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STALL   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               prev_q, prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               period_valid_q, period_valid_d;
    logic               stalled_q, stalled_d;
    logic               tick_q, tick_d;
    logic [15:0]        tick_count_q, tick_count_d;
    logic               w_qual_edge;

`ifdef TICK_BOTH_EDGES_EN
    assign w_qual_edge = sync2_q ^ prev_q;
`else
    assign w_qual_edge = sync2_q & ~prev_q;
`endif

    always_comb begin
        sync1_d        = slow_clk_in;
        sync2_d        = sync1_q;
        prev_d         = sync2_q;
        state_d        = state_q;
        cnt_d          = '0;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        stalled_d      = stalled_q;
        tick_d         = w_qual_edge & enable;
        tick_count_d   = tick_d ? tick_count_q + 16'd1 : tick_count_q;

        case (state_q)
            ST_IDLE: begin
                if (w_qual_edge) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // An edge landing on the timeout cycle still counts as a valid period.
                if (w_qual_edge) begin
                    period_d       = cnt_q + C_ONE;
                    period_valid_d = 1'b1;
                end else if (cnt_q == C_TIMEOUT_LAST) begin
                    state_d        = ST_STALL;
                    stalled_d      = 1'b1;
                    period_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            ST_STALL: begin
                if (w_qual_edge) begin
                    state_d   = ST_MEASURE;
                    stalled_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            prev_q         <= 1'b0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b0;
            tick_q         <= 1'b0;
            tick_count_q   <= 16'd0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            prev_q         <= prev_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stalled_q      <= stalled_d;
            tick_q         <= tick_d;
            tick_count_q   <= tick_count_d;
        end
    end

    assign tick         = tick_q;
    assign tick_count   = tick_count_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stalled      = stalled_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_receiver
//  Purpose  : Directed self-checking bench for tick_receiver (TIMEOUT = 20).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tick_receiver;

    logic        clk;
    logic        rst;
    logic        slow_clk_in;
    logic        enable;
    logic        tick;
    logic [15:0] tick_count;
    logic [31:0] period;
    logic        period_valid;
    logic        stalled;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tick_cycs[$];
    int stall_rises    = 0;
    int stall_rise_cyc = 0;
    logic stalled_prev = 1'b0;

    tick_receiver #(
        .CNT_W   (32),
        .TIMEOUT (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .slow_clk_in  (slow_clk_in),
        .enable       (enable),
        .tick         (tick),
        .tick_count   (tick_count),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; outputs are observed 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tick === 1'b1) tick_cycs.push_back(cyc);
        if (stalled === 1'b1 && stalled_prev !== 1'b1) begin
            stall_rises++;
            stall_rise_cyc = cyc;
        end
        stalled_prev = stalled;
    endtask

    task automatic run(input logic v, input int n);
        slow_clk_in = v;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        slow_clk_in = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        tick_cycs.delete();
        stall_rises = 0;
        stalled_prev = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        rst = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slow_clk_in = (i % 2 == 0);
            step();
            checks++; if ({tick, tick_count, period, period_valid, stalled} !== 51'd0) begin errors++; $display("FAIL reset_outputs cycle %0d: got tick=%b cnt=%0d per=%0d pv=%b st=%b expected all 0", i, tick, tick_count, period, period_valid, stalled); end
        end
        rst = 1'b0;
        tick_cycs.delete();
        run(1'b0, 2);
        checks++; if (tick_cycs.size() !== 0) begin errors++; $display("FAIL reset_no_spurious_tick: got %0d ticks expected 0", tick_cycs.size()); end
        c = cyc;
        run(1'b1, 5);
        checks++; if (tick_cycs.size() !== 1) begin errors++; $display("FAIL reset_first_tick_count: got %0d ticks expected 1", tick_cycs.size()); end
        checks++; if (tick_cycs.size() > 0 && tick_cycs[0] !== c + 3) begin errors++; $display("FAIL reset_first_tick_latency: got cycle %0d expected %0d", tick_cycs[0], c + 3); end
        checks++; if (tick_count !== 16'd1) begin errors++; $display("FAIL reset_tick_count: got %0d expected 1", tick_count); end
        checks++; if (period_valid !== 1'b0 || period !== 32'd0) begin errors++; $display("FAIL reset_first_no_period: got pv=%b per=%0d expected pv=0 per=0", period_valid, period); end
    endtask

    task automatic test_steady();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run(1'b1, 8);
            run(1'b0, 8);
        end
        checks++; if (tick_cycs.size() !== 5) begin errors++; $display("FAIL steady_ticks: got %0d expected 5", tick_cycs.size()); end
        for (int i = 1; i < tick_cycs.size(); i++) begin
            checks++; if (tick_cycs[i] - tick_cycs[i-1] !== 16) begin errors++; $display("FAIL steady_interval %0d: got %0d expected 16", i, tick_cycs[i] - tick_cycs[i-1]); end
        end
        checks++; if (tick_count !== 16'd5) begin errors++; $display("FAIL steady_tick_count: got %0d expected 5", tick_count); end
        checks++; if (period !== 32'd16 || period_valid !== 1'b1) begin errors++; $display("FAIL steady_period: got per=%0d pv=%b expected per=16 pv=1", period, period_valid); end
    endtask

    task automatic test_enable();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            run(1'b1, 8);
            run(1'b0, 8);
        end
        enable = 1'b0;
        tick_cycs.delete();
        for (int i = 0; i < 3; i++) begin
            run(1'b1, 6);
            run(1'b0, 6);
        end
        checks++; if (tick_cycs.size() !== 0) begin errors++; $display("FAIL enable_suppressed_ticks: got %0d expected 0", tick_cycs.size()); end
        checks++; if (tick_count !== 16'd2) begin errors++; $display("FAIL enable_count_held: got %0d expected 2", tick_count); end
        checks++; if (period !== 32'd12 || period_valid !== 1'b1) begin errors++; $display("FAIL enable_period_runs: got per=%0d pv=%b expected per=12 pv=1", period, period_valid); end
        enable = 1'b1;
        run(1'b1, 6);
        run(1'b0, 6);
        checks++; if (tick_cycs.size() !== 1 || tick_count !== 16'd3) begin errors++; $display("FAIL enable_resume: got ticks=%0d cnt=%0d expected ticks=1 cnt=3", tick_cycs.size(), tick_count); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            run(1'b1, 8);
            run(1'b0, 8);
        end
        run(1'b1, 8);
        run(1'b0, 25);
        checks++; if (stall_rises !== 1) begin errors++; $display("FAIL stall_rises: got %0d expected 1", stall_rises); end
        checks++; if (tick_cycs.size() === 3 && stall_rise_cyc - tick_cycs[2] !== 20) begin errors++; $display("FAIL stall_timing: got %0d cycles expected 20", stall_rise_cyc - tick_cycs[2]); end
        checks++; if (stalled !== 1'b1 || period_valid !== 1'b0 || period !== 32'd16) begin errors++; $display("FAIL stall_state: got st=%b pv=%b per=%0d expected st=1 pv=0 per=16", stalled, period_valid, period); end
        run(1'b1, 4);
        checks++; if (stalled !== 1'b0 || tick_cycs.size() !== 4 || tick_count !== 16'd4) begin errors++; $display("FAIL stall_recover: got st=%b ticks=%0d cnt=%0d expected st=0 ticks=4 cnt=4", stalled, tick_cycs.size(), tick_count); end
        checks++; if (period !== 32'd16 || period_valid !== 1'b0) begin errors++; $display("FAIL stall_period_kept: got per=%0d pv=%b expected per=16 pv=0", period, period_valid); end
    endtask

    task automatic test_edge_vs_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run(1'b1, 10);
            run(1'b0, 10);
        end
        checks++; if (stall_rises !== 0 || period !== 32'd20 || period_valid !== 1'b1) begin errors++; $display("FAIL edge_wins: got rises=%0d per=%0d pv=%b expected rises=0 per=20 pv=1", stall_rises, period, period_valid); end
        run(1'b0, 1);
        run(1'b1, 4);
        checks++; if (stall_rises !== 1 || stalled !== 1'b0 || period !== 32'd20) begin errors++; $display("FAIL one_past_timeout: got rises=%0d st=%b per=%0d expected rises=1 st=0 per=20", stall_rises, stalled, period); end
        checks++; if (tick_count !== 16'd5) begin errors++; $display("FAIL edge_vs_timeout_count: got %0d expected 5", tick_count); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_cnt [3];
        exp_cnt[0] = 16'hFFFE;
        exp_cnt[1] = 16'hFFFF;
        exp_cnt[2] = 16'h0000;
        do_reset();
        force dut.tick_count_q = 16'hFFFD;
        step();
        release dut.tick_count_q;
        for (int i = 0; i < 3; i++) begin
            run(1'b1, 2);
            run(1'b0, 2);
            checks++; if (tick_count !== exp_cnt[i]) begin errors++; $display("FAIL wrap_count %0d: got %h expected %h", i, tick_count, exp_cnt[i]); end
        end
        checks++; if (period !== 32'd4) begin errors++; $display("FAIL wrap_period: got %0d expected 4", period); end
    endtask

    task automatic test_both_edges();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run(1'b1, 8);
            run(1'b0, 8);
        end
        checks++; if (tick_cycs.size() !== 8 || tick_count !== 16'd8) begin errors++; $display("FAIL both_ticks: got ticks=%0d cnt=%0d expected 8", tick_cycs.size(), tick_count); end
        for (int i = 1; i < tick_cycs.size(); i++) begin
            checks++; if (tick_cycs[i] - tick_cycs[i-1] !== 8) begin errors++; $display("FAIL both_interval %0d: got %0d expected 8", i, tick_cycs[i] - tick_cycs[i-1]); end
        end
        checks++; if (period !== 32'd8 || period_valid !== 1'b1) begin errors++; $display("FAIL both_period: got per=%0d pv=%b expected per=8 pv=1", period, period_valid); end
    endtask

    initial begin
        rst = 1'b1;
        slow_clk_in = 1'b0;
        enable = 1'b1;
        test_reset();
`ifdef TICK_BOTH_EDGES_EN
        test_both_edges();
`else
        test_steady();
        test_enable();
        test_stall();
        test_edge_vs_timeout();
        test_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
